// File: rtl/disp_chan_sel.sv
// Display channel selector: a mode button steps through channels, the view
// returns to the timer channel after a period of inactivity, and a blink
// mask blanks digits during the off phase on every channel except the timer.
module disp_chan_sel #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int TIMEOUT  = 30
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode_btn,
  input  logic                      tick_1hz,
  input  logic                      tick_blink,
  input  logic [CHANNELS*WIDTH-1:0] chan_data,
  input  logic [WIDTH-1:0]          blink_mask,
  output logic [WIDTH-1:0]          output_data,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      sel_changed
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

  logic             btn_q;
  logic             btn_armed;
  logic             press;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_cnt_next;
  logic [SEL_W-1:0] sel_next;
  logic             blink_phase;
  logic [WIDTH-1:0] slice;

  // btn_armed keeps a button held across reset release from counting as a press.
  assign press = mode_btn && !btn_q && btn_armed;
  assign slice = chan_data[int'(cur_sel)*WIDTH +: WIDTH];

  // NOTE: every output of a combinational block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sel_next      = cur_sel;
    idle_cnt_next = idle_cnt;
    if (press) begin
      sel_next      = (cur_sel == SEL_LAST) ? '0 : cur_sel + 1'b1;
      idle_cnt_next = '0;
    end else if (cur_sel == '0) begin
      idle_cnt_next = '0;
    end else if (tick_1hz && TIMEOUT != 0) begin
      if (idle_cnt == CNT_LAST) begin
        sel_next      = '0;
        idle_cnt_next = '0;
      end else begin
        idle_cnt_next = idle_cnt + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q       <= 1'b0;
      btn_armed   <= !mode_btn;
      idle_cnt    <= '0;
      cur_sel     <= '0;
      sel_changed <= 1'b0;
      blink_phase <= 1'b1;
      output_data <= '0;
    end else begin
      btn_q       <= mode_btn;
      btn_armed   <= btn_armed || !mode_btn;
      idle_cnt    <= idle_cnt_next;
      cur_sel     <= sel_next;
      sel_changed <= (sel_next != cur_sel);
      if (sel_next != cur_sel)
        blink_phase <= 1'b1;
      else if (tick_blink)
        blink_phase <= !blink_phase;
      if (cur_sel != '0 && !blink_phase)
        output_data <= slice | blink_mask;
      else
        output_data <= slice;
    end
  end

endmodule

// File: tb/tb_disp_chan_sel.sv
// Directed bench for disp_chan_sel with WIDTH=24, CHANNELS=4, TIMEOUT=3.
module tb_disp_chan_sel;

  localparam int WIDTH    = 24;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      mode_btn;
  logic                      tick_1hz;
  logic                      tick_blink;
  logic [CHANNELS*WIDTH-1:0] chan_data;
  logic [WIDTH-1:0]          blink_mask;
  logic [WIDTH-1:0]          output_data;
  logic [SEL_W-1:0]          cur_sel;
  logic                      sel_changed;

  int tests_run = 0;
  int tests_failed = 0;

  disp_chan_sel #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .TIMEOUT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .tick_1hz(tick_1hz),
    .tick_blink(tick_blink), .chan_data(chan_data), .blink_mask(blink_mask),
    .output_data(output_data), .cur_sel(cur_sel), .sel_changed(sel_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs changed afterwards are sampled at the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    mode_btn = 1'b1; cyc();
    mode_btn = 1'b0; cyc();
  endtask

  initial begin
    rst_n = 1'b0; mode_btn = 1'b0; tick_1hz = 1'b0; tick_blink = 1'b0;
    blink_mask = '0;
    chan_data = {24'h444444, 24'h333333, 24'h222222, 24'h111111};

    // Reset state, then channel 0 visible after release.
    cyc(); cyc();
    check("rst_sel", 32'(cur_sel), 32'd0);
    check("rst_out", 32'(output_data), 32'd0);
    check("rst_chg", 32'(sel_changed), 32'd0);
    rst_n = 1'b1;
    cyc(); cyc();
    check("idle_sel", 32'(cur_sel), 32'd0);
    check("idle_out", 32'(output_data), 32'h111111);

    // Four presses walk 1,2,3,0 with output two edges after the press.
    mode_btn = 1'b1; cyc();
    check("p1_sel", 32'(cur_sel), 32'd1); check("p1_chg", 32'(sel_changed), 32'd1);
    mode_btn = 1'b0; cyc();
    check("p1_out", 32'(output_data), 32'h222222); check("p1_chg_lo", 32'(sel_changed), 32'd0);
    mode_btn = 1'b1; cyc();
    check("p2_sel", 32'(cur_sel), 32'd2); check("p2_chg", 32'(sel_changed), 32'd1);
    mode_btn = 1'b0; cyc();
    check("p2_out", 32'(output_data), 32'h333333);
    mode_btn = 1'b1; cyc();
    check("p3_sel", 32'(cur_sel), 32'd3); check("p3_chg", 32'(sel_changed), 32'd1);
    mode_btn = 1'b0; cyc();
    check("p3_out", 32'(output_data), 32'h444444);
    mode_btn = 1'b1; cyc();
    check("p4_wrap_sel", 32'(cur_sel), 32'd0); check("p4_wrap_chg", 32'(sel_changed), 32'd1);
    mode_btn = 1'b0; cyc();
    check("p4_out", 32'(output_data), 32'h111111);

    // Held button: exactly one advance.
    mode_btn = 1'b1; cyc();
    check("hold_sel", 32'(cur_sel), 32'd1); check("hold_chg", 32'(sel_changed), 32'd1);
    for (int i = 0; i < 19; i++) begin
      cyc();
      check("hold_no_chg", 32'(sel_changed), 32'd0);
    end
    check("hold_sel_end", 32'(cur_sel), 32'd1);
    mode_btn = 1'b0; cyc();

    // Auto-return from channel 2 on the third idle tick.
    press();
    check("to_start", 32'(cur_sel), 32'd2);
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    check("to_2ticks", 32'(cur_sel), 32'd2);
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    check("to_ret_sel", 32'(cur_sel), 32'd0); check("to_ret_chg", 32'(sel_changed), 32'd1);
    cyc();

    // Press coincident with the third tick wins.
    press(); press();
    check("pw_start", 32'(cur_sel), 32'd2);
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    tick_1hz = 1'b1; mode_btn = 1'b1; cyc();
    tick_1hz = 1'b0; mode_btn = 1'b0;
    check("pw_sel", 32'(cur_sel), 32'd3);
    cyc();

    // Blink on channel 1.
    press(); press();
    check("bl_start", 32'(cur_sel), 32'd1);
    blink_mask = 24'h0000FF;
    tick_blink = 1'b1; cyc(); tick_blink = 1'b0; cyc();
    check("bl_off", 32'(output_data), 32'h2222FF);
    tick_blink = 1'b1; cyc(); tick_blink = 1'b0; cyc();
    check("bl_on", 32'(output_data), 32'h222222);

    // Same stimulus on channel 0: never blanks.
    press(); press(); press();
    check("bl0_start", 32'(cur_sel), 32'd0);
    tick_blink = 1'b1; cyc(); tick_blink = 1'b0; cyc();
    check("bl0_a", 32'(output_data), 32'h111111);
    tick_blink = 1'b1; cyc(); tick_blink = 1'b0; cyc();
    check("bl0_b", 32'(output_data), 32'h111111);

    // Reset on channel 3 overrides a coincident timeout, press and blink tick.
    press(); press(); press();
    check("mr_start", 32'(cur_sel), 32'd3);
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    rst_n = 1'b0; tick_1hz = 1'b1; tick_blink = 1'b1; mode_btn = 1'b1; cyc();
    check("mr_sel", 32'(cur_sel), 32'd0);
    check("mr_out", 32'(output_data), 32'd0);
    check("mr_chg", 32'(sel_changed), 32'd0);

    // Button still held across release: no press until released and re-pressed.
    rst_n = 1'b1; tick_1hz = 1'b0; tick_blink = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hr_sel", 32'(cur_sel), 32'd0);
      check("hr_chg", 32'(sel_changed), 32'd0);
    end
    mode_btn = 1'b0; cyc();
    mode_btn = 1'b1; cyc();
    check("hr_repress", 32'(cur_sel), 32'd1);
    mode_btn = 1'b0; cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
